// File: rtl/dual_address_ram_pkg.sv
// Shared sizes and types for the dual-address RAM.
package dual_address_ram_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef data_t             mem_t [DEPTH];

endpackage

// File: rtl/dual_address_ram_if.sv
// Bus bundle for the dual-address RAM: shared write data, per-port address/role and read data.
interface dual_address_ram_if;
  import dual_address_ram_pkg::*;

  logic  wr_en;
  data_t data_in;
  addr_t addr_in_0;
  addr_t addr_in_1;
  logic  port_en_0;
  logic  port_en_1;
  data_t data_out_0;
  data_t data_out_1;

  modport master (
    output wr_en, data_in, addr_in_0, addr_in_1, port_en_0, port_en_1,
    input  data_out_0, data_out_1
  );

  modport slave (
    input  wr_en, data_in, addr_in_0, addr_in_1, port_en_0, port_en_1,
    output data_out_0, data_out_1
  );

endinterface

// File: rtl/dual_address_ram_rd_port.sv
// One read port: address mux with zero forcing in write mode, plus an optional output register
// when DUAL_ADDRESS_RAM_REG_OUT_EN is defined.
module dual_address_ram_rd_port
  import dual_address_ram_pkg::*;
(
`ifdef DUAL_ADDRESS_RAM_REG_OUT_EN
  input  logic  clk,
  input  logic  rst_n,
`endif
  input  mem_t  mem,
  input  addr_t addr,
  input  logic  port_en,
  output data_t data_out
);

  data_t rd_word;

  // A port in write mode presents zero instead of its addressed word.
  always_comb begin
    rd_word = '0;
    if (!port_en) begin
      rd_word = mem[addr];
    end
  end

`ifdef DUAL_ADDRESS_RAM_REG_OUT_EN
  data_t data_q;

  // Samples the pre-edge array, so a same-edge write on the other port returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= rd_word;
    end
  end

  assign data_out = data_q;
`else
  assign data_out = rd_word;
`endif

endmodule

// File: rtl/dual_address_ram.sv
// 16x8 RAM with two address ports sharing one write-data bus and a global write enable.
// Each port writes when its enable is high and reads when low.
// Optional: DUAL_ADDRESS_RAM_REG_OUT_EN registers the read outputs (1-cycle latency).
module dual_address_ram
  import dual_address_ram_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  dual_address_ram_if.slave bus
);

  mem_t mem;

  // Array storage; both ports may write the same address since the data is shared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (bus.wr_en) begin
      if (bus.port_en_0) begin
        mem[bus.addr_in_0] <= bus.data_in;
      end
      if (bus.port_en_1) begin
        mem[bus.addr_in_1] <= bus.data_in;
      end
    end
  end

  dual_address_ram_rd_port u_rd_port_0 (
`ifdef DUAL_ADDRESS_RAM_REG_OUT_EN
    .clk      (clk),
    .rst_n    (rst_n),
`endif
    .mem      (mem),
    .addr     (bus.addr_in_0),
    .port_en  (bus.port_en_0),
    .data_out (bus.data_out_0)
  );

  dual_address_ram_rd_port u_rd_port_1 (
`ifdef DUAL_ADDRESS_RAM_REG_OUT_EN
    .clk      (clk),
    .rst_n    (rst_n),
`endif
    .mem      (mem),
    .addr     (bus.addr_in_1),
    .port_en  (bus.port_en_1),
    .data_out (bus.data_out_1)
  );

endmodule

// File: tb/tb_dual_address_ram.sv
// Self-checking bench for dual_address_ram: directed scenarios plus random traffic against an
// array model of the RAM. Honours DUAL_ADDRESS_RAM_REG_OUT_EN for the expected read latency.
module tb_dual_address_ram;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [7:0] ref_mem [16];
  logic [7:0] reg_exp [2];

  dual_address_ram_if bus ();

  dual_address_ram dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    reg_exp[0] = 8'h00;
    reg_exp[1] = 8'h00;
  endtask

  task automatic drive(input logic we, input logic e0, input logic e1,
                       input logic [3:0] a0, input logic [3:0] a1, input logic [7:0] d);
    bus.wr_en     = we;
    bus.port_en_0 = e0;
    bus.port_en_1 = e1;
    bus.addr_in_0 = a0;
    bus.addr_in_1 = a1;
    bus.data_in   = d;
  endtask

  // Rising edge as seen by the model: reads capture the old words, then writes land.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      clear_model();
    end else begin
      reg_exp[0] = bus.port_en_0 ? 8'h00 : ref_mem[bus.addr_in_0];
      reg_exp[1] = bus.port_en_1 ? 8'h00 : ref_mem[bus.addr_in_1];
      if (bus.wr_en && bus.port_en_0) ref_mem[bus.addr_in_0] = bus.data_in;
      if (bus.wr_en && bus.port_en_1) ref_mem[bus.addr_in_1] = bus.data_in;
    end
    #1;
  endtask

  // Check both outputs mid-cycle against the model, then advance one edge.
  task automatic cycle(input string tag);
    logic [7:0] e0, e1;
    @(negedge clk);
`ifdef DUAL_ADDRESS_RAM_REG_OUT_EN
    e0 = reg_exp[0];
    e1 = reg_exp[1];
`else
    e0 = bus.port_en_0 ? 8'h00 : ref_mem[bus.addr_in_0];
    e1 = bus.port_en_1 ? 8'h00 : ref_mem[bus.addr_in_1];
`endif
    check_eq({tag, ".out0"}, bus.data_out_0, e0);
    check_eq({tag, ".out1"}, bus.data_out_1, e1);
    tick();
  endtask

  // Asynchronous reset pulse wholly between clock edges.
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    check_eq("rst.out0", bus.data_out_0, 8'h00);
    check_eq("rst.out1", bus.data_out_1, 8'h00);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b0, 4'(i), 4'(15 - i), 8'h00);
      cycle(tag);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
    cycle(tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_model();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();

    // 1. Dirty a few words, then reset asynchronously and sweep.
    drive(1'b1, 1'b1, 1'b1, 4'd4, 4'd11, 8'h5A);
    cycle("pre");
    drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd4, 8'hC3);
    cycle("pre");
    drive(1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 8'h00);
    cycle("pre");
    pulse_reset();
    sweep_zero("sweep");

    // 2. Port-0 fill with i+1, port 1 reading alongside.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'(i), 4'(i), 8'(i + 1));
      cycle("fill");
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd5, 8'h00);
    cycle("rd5");
    check_eq("fill.a5", bus.data_out_1, 8'h06);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd15, 8'h00);
    cycle("rd15");
    check_eq("fill.a15", bus.data_out_1, 8'h10);

    // 3. Dual write to different addresses.
    drive(1'b1, 1'b1, 1'b1, 4'd3, 4'd9, 8'hA5);
    cycle("dual");
    drive(1'b0, 1'b0, 1'b0, 4'd3, 4'd9, 8'h00);
    cycle("dualrd");
    check_eq("dual.m3", bus.data_out_0, 8'hA5);
    check_eq("dual.m9", bus.data_out_1, 8'hA5);

    // 4. Write mode without wr_en: no write, output forced to zero.
    drive(1'b0, 1'b1, 1'b0, 4'd2, 4'd2, 8'hFF);
    cycle("nowe");
    check_eq("nowe.out0", bus.data_out_0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 4'd2, 4'd2, 8'h00);
    cycle("nowerd");
    check_eq("nowe.m2", bus.data_out_0, 8'h03);

    // 5. Collision: port 0 writes addr 7 while port 1 reads it.
    drive(1'b1, 1'b1, 1'b0, 4'd7, 4'd7, 8'h3C);
    cycle("coll");
`ifdef DUAL_ADDRESS_RAM_REG_OUT_EN
    check_eq("coll.old", bus.data_out_1, 8'h08);
`else
    check_eq("coll.new", bus.data_out_1, 8'h3C);
`endif
    drive(1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 8'h00);
    cycle("collrd");
    check_eq("coll.final", bus.data_out_1, 8'h3C);

    // 6. Reset asserted during a write burst, held across the edge of the targeted write.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 4'(i), 4'(15 - i), 8'(8'h80 + i));
      cycle("burst");
    end
    drive(1'b1, 1'b1, 1'b0, 4'd12, 4'd12, 8'hEE);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    clear_model();
    #1;
    check_eq("midrst.out0", bus.data_out_0, 8'h00);
    check_eq("midrst.out1", bus.data_out_1, 8'h00);
    tick();
    #2;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'd12, 4'd12, 8'h00);
    cycle("midrstrd");
    check_eq("midrst.m12", bus.data_out_1, 8'h00);
    sweep_zero("midsweep");

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom), 4'($urandom), 8'($urandom));
      cycle("rand");
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b0, 4'(i), 4'(i ^ 5), 8'h00);
      cycle("final");
    end
    cycle("final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
